// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: size encodings, FSM states and byte-lane mask.
package mem_resp_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    MERGE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The reserved size encoding falls through to a full-word mask.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_BYTE: m = 4'b0001 << addr_lo;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_resp_lane_merge.sv
// Combinational store merge: right-justified store data is placed into the selected little-endian lanes.
module mem_resp_lane_merge
  import mem_resp_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged,
  output logic [3:0]  be
);

  logic [31:0] wrep;

  always_comb begin
    case (size)
      SIZE_HALF: wrep = {2{wdata[15:0]}};
      SIZE_BYTE: wrep = {4{wdata[7:0]}};
      default:   wrep = wdata;
    endcase
    be = lane_mask(size, addr_lo);
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = wrep[8*k +: 8];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder with read-modify-write sub-word stores.
// Optional misalignment reporting is enabled by defining MEM_RESP_ALIGN_CHECK_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               req_write_q;
  logic [1:0]         req_size_q;
  logic [1:0]         addr_lo_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic [31:0]        mem [DEPTH];
  logic [31:0]        old_word, merged;
  logic [3:0]         be;
  logic               accept, misalign;
  logic               unused_addr_hi;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign old_word   = mem[idx_q];
  // Address bits above the word index are dropped so accesses wrap modulo DEPTH.
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign misalign = (req_size_q == SIZE_HALF) ? addr_lo_q[0]
                  : ((req_size_q != SIZE_BYTE) && (addr_lo_q != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  mem_resp_lane_merge u_merge (
    .old_word (old_word),
    .wdata    (wdata_q),
    .size     (req_size_q),
    .addr_lo  (addr_lo_q),
    .merged   (merged),
    .be       (be)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY > 0) ? WAIT : MERGE;
      WAIT:    if (cnt == '0) state_nxt = MERGE;
      MERGE:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_write_q <= req_write;
      req_size_q  <= req_size;
      addr_lo_q   <= req_addr[1:0];
      idx_q       <= req_addr[IDX_W+1:2];
      wdata_q     <= req_wdata;
    end
  end

  // Stores commit lane by lane at the MERGE edge; misaligned requests leave the array untouched.
  always_ff @(posedge clk) begin
    if (state == MERGE && req_write_q && !misalign) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx_q][8*k +: 8] <= merged[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_rdata <= '0;
    end else if (state == MERGE) begin
      resp_rdata <= misalign ? 32'h0 : (req_write_q ? merged : old_word);
    end
  end

`ifdef MEM_RESP_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              resp_err <= 1'b0;
    else if (state == MERGE)   resp_err <= misalign;
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance 0 with LATENCY=2, instance 1 with LATENCY=0.
module tb_mem_responder;
  import mem_resp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n    [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [1:0]  req_size   [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(256), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  mem_responder #(.DEPTH(256), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  function automatic int exp_lat(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic accept(input int d, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
    int n;
    @(negedge clk);
    req_write[d] = wr; req_size[d] = sz; req_addr[d] = addr; req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready[d] !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready dut%0d: req_ready=%b required=1", d, req_ready[d]);
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    sb.push_back('{er, ee});
  endtask

  task automatic complete(input int d, input int stall);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!resp_valid[d] && n < 50);
    checks++;
    if (n != exp_lat(d) || resp_valid[d] !== 1'b1) begin
      failures++;
      $display("FAIL latency dut%0d: cycles=%0d resp_valid=%b required=%0d", d, n, resp_valid[d], exp_lat(d));
    end
    e = sb.pop_front();
    checks++;
    if (resp_rdata[d] !== e.rdata) begin
      failures++;
      $display("FAIL rdata dut%0d: got=%h required=%h", d, resp_rdata[d], e.rdata);
    end
    checks++;
    if (resp_err[d] !== e.err) begin
      failures++;
      $display("FAIL err dut%0d: got=%b required=%b", d, resp_err[d], e.err);
    end
    if (stall > 0) begin
      req_write[d] = 1'b1; req_size[d] = SIZE_WORD; req_addr[d] = 32'h40;
      req_wdata[d] = 32'h9999_9999; req_valid[d] = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== e.rdata || req_ready[d] !== 1'b0) begin
        failures++;
        $display("FAIL stall dut%0d cyc%0d: valid=%b rdata=%h ready=%b required 1/%h/0",
                 d, i, resp_valid[d], resp_rdata[d], req_ready[d], e.rdata);
      end
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
    checks++;
    if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0) begin
      failures++;
      $display("FAIL handshake dut%0d: req_ready=%b resp_valid=%b required 1/0", d, req_ready[d], resp_valid[d]);
    end
    if (stall > 0) begin
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0) begin
        failures++;
        $display("FAIL single_transfer dut%0d: req_ready=%b resp_valid=%b required 1/0",
                 d, req_ready[d], resp_valid[d]);
      end
    end
  endtask

  task automatic xfer(input int d, input logic wr, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input int stall);
    accept(d, wr, sz, addr, wd, er, ee);
    complete(d, stall);
  endtask

  task automatic test_reset;
    reset_n[0] = 1'b0; reset_n[1] = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
          resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
      end
    end
    repeat (2) @(negedge clk);
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;
  endtask

  task automatic test_word;
    xfer(0, 1'b1, SIZE_WORD, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
    xfer(0, 1'b0, SIZE_WORD, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
  endtask

  task automatic test_subword;
    xfer(0, 1'b1, SIZE_BYTE, 32'h11, 32'h0000_00AA, 32'hDEAD_AAEF, 1'b0, 0);
    xfer(0, 1'b1, SIZE_HALF, 32'h12, 32'h0000_1234, 32'h1234_AAEF, 1'b0, 0);
    xfer(0, 1'b0, SIZE_WORD, 32'h10, 32'h0,         32'h1234_AAEF, 1'b0, 0);
  endtask

  task automatic test_wrap;
    xfer(0, 1'b0, SIZE_WORD, 32'h10 + 32'd4 * 32'd256, 32'h0, 32'h1234_AAEF, 1'b0, 0);
    xfer(0, 1'b1, SIZE_BYTE, 32'h413, 32'h0000_0055, 32'h5534_AAEF, 1'b0, 0);
    xfer(0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 32'h5534_AAEF, 1'b0, 0);
  endtask

  task automatic test_stall;
    xfer(0, 1'b1, SIZE_WORD, 32'h40, 32'h1111_2222, 32'h1111_2222, 1'b0, 0);
    xfer(0, 1'b0, SIZE_WORD, 32'h40, 32'h0,         32'h1111_2222, 1'b0, 5);
    xfer(0, 1'b0, SIZE_WORD, 32'h40, 32'h0,         32'h1111_2222, 1'b0, 0);
  endtask

  task automatic test_latency0;
    xfer(1, 1'b1, SIZE_WORD, 32'h08, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 0);
    xfer(1, 1'b1, SIZE_BYTE, 32'h0A, 32'h0000_003C, 32'hA53C_A5A5, 1'b0, 0);
    xfer(1, 1'b0, SIZE_WORD, 32'h08, 32'h0,         32'hA53C_A5A5, 1'b0, 0);
  endtask

  task automatic test_reset_mid;
    xfer(0, 1'b1, SIZE_WORD, 32'h20, 32'h0, 32'h0, 1'b0, 0);
    accept(0, 1'b1, SIZE_WORD, 32'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    #2;
    reset_n[0] = 1'b0;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 ||
        resp_rdata[0] !== 32'h0 || resp_err[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
               req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0]);
    end
    sb.delete();
    @(negedge clk);
    reset_n[0] = 1'b1;
    xfer(0, 1'b0, SIZE_WORD, 32'h20, 32'h0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_align;
`ifdef MEM_RESP_ALIGN_CHECK_EN
    xfer(0, 1'b1, SIZE_WORD, 32'h22, 32'hCAFE_F00D, 32'h0, 1'b1, 0);
    xfer(0, 1'b0, SIZE_WORD, 32'h20, 32'h0,         32'h0, 1'b0, 0);
`else
    xfer(0, 1'b1, SIZE_WORD, 32'h22, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 0);
    xfer(0, 1'b0, SIZE_WORD, 32'h20, 32'h0,         32'hCAFE_F00D, 1'b0, 0);
`endif
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = SIZE_WORD;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; resp_ready[d] = 1'b0;
    end
    test_reset();
    test_word();
    test_subword();
    test_wrap();
    test_stall();
    test_latency0();
    test_reset_mid();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
